// File: rtl/rpi_image_sync_if.sv
// Bus bundle between the SPI front end / application and rpi_image_sync.
interface rpi_image_sync_if #(
  parameter int unsigned N_BYTES = 128
);
  logic [N_BYTES*8-1:0] TX_IMAGE;
  logic                 SNAP_REQ;
  logic [N_BYTES*8-1:0] SNAP_DATA;
  logic                 SNAP_VALID;
  logic [7:0]           RX_BYTE;
  logic                 RX_BYTE_VALID;
  logic                 XFER_END;
  logic [N_BYTES*8-1:0] RX_IMAGE;
  logic                 RX_UPDATE;
  logic                 XFER_ERR;
  logic                 LINK_OK;

  // Application / SPI side: drives live image and SPI events
  modport master (
    output TX_IMAGE, SNAP_REQ, RX_BYTE, RX_BYTE_VALID, XFER_END,
    input  SNAP_DATA, SNAP_VALID, RX_IMAGE, RX_UPDATE, XFER_ERR, LINK_OK
  );

  // Synchroniser side
  modport slave (
    input  TX_IMAGE, SNAP_REQ, RX_BYTE, RX_BYTE_VALID, XFER_END,
    output SNAP_DATA, SNAP_VALID, RX_IMAGE, RX_UPDATE, XFER_ERR, LINK_OK
  );
endinterface

// File: rtl/rpi_image_sync.sv
// Process-image synchroniser for an RPI SPI link: freezes the outgoing image at
// chip-select, collects the incoming image into a shadow and commits it only for
// complete transfers; a watchdog clears the image when commits stop arriving.
module rpi_image_sync #(
  parameter int unsigned N_BYTES    = 128,
  parameter bit          BIT_REV    = 1'b1,
  parameter int unsigned WDT_CYCLES = 5000000
) (
  input logic            CLK,
  input logic            RESET_N,
  rpi_image_sync_if.slave bus
);

  localparam int unsigned IMG_W = N_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(N_BYTES + 1);
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N_BYTES);
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state_q,      state_d;
  logic [IMG_W-1:0]   snap_q,       snap_d;
  logic               snap_valid_q, snap_valid_d;
  logic [7:0]         seq_q,        seq_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               ovf_q,        ovf_d;
  logic [IMG_W-1:0]   shadow_q,     shadow_d;
  logic [IMG_W-1:0]   rx_image_q,   rx_image_d;
  logic               rx_update_q,  rx_update_d;
  logic               xfer_err_q,   xfer_err_d;
  logic               link_ok_q,    link_ok_d;
  logic [WDT_W-1:0]   wdt_q,        wdt_d;

  logic               take_snap;
  logic [CNT_W-1:0]   cnt_eff;
  logic               ovf_eff;
  logic [7:0]         rx_ord;

  // Wire-order conversion between natural byte order and SPI shift order
  function automatic logic [7:0] bit_order(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (BIT_REV) begin
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
    end
    return r;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    seq_d        = seq_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    shadow_d     = shadow_q;
    rx_image_d   = rx_image_q;
    link_ok_d    = link_ok_q;
    wdt_d        = wdt_q;
    rx_update_d  = 1'b0;
    xfer_err_d   = 1'b0;
    take_snap    = 1'b0;
    cnt_eff      = cnt_q;
    ovf_eff      = ovf_q;
    rx_ord       = bit_order(bus.RX_BYTE);

    // Watchdog: saturating count; expiry is re-applied every cycle while saturated
    if (WDT_CYCLES != 0) begin
      if (wdt_q == WDT_LIMIT) begin
        rx_image_d = '0;
        link_ok_d  = 1'b0;
      end else begin
        wdt_d = wdt_q + WDT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.SNAP_REQ) take_snap = 1'b1;
      end
      XFER: begin
        if (bus.SNAP_REQ) begin
          // New chip-select before the old one ended: abandon and restart
          take_snap  = 1'b1;
          xfer_err_d = 1'b1;
        end else begin
          if (bus.RX_BYTE_VALID) begin
            if (cnt_q == CNT_FULL) begin
              ovf_eff = 1'b1;
            end else begin
              for (int k = 0; k < N_BYTES; k++) begin
                if (cnt_q == CNT_W'(k)) shadow_d[k*8 +: 8] = rx_ord;
              end
              cnt_eff = cnt_q + CNT_W'(1);
            end
          end
          cnt_d = cnt_eff;
          ovf_d = ovf_eff;
          if (bus.XFER_END) begin
            state_d      = IDLE;
            snap_valid_d = 1'b0;
            if (cnt_eff == CNT_FULL && !ovf_eff) begin
              // Commit overrides a coincident watchdog expiry
              rx_image_d  = shadow_d;
              rx_update_d = 1'b1;
              link_ok_d   = 1'b1;
              wdt_d       = '0;
            end else begin
              xfer_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot: sequence number in byte 0, live image in bytes 1..N-1
    if (take_snap) begin
      snap_d[7:0] = bit_order(seq_q);
      for (int k = 1; k < N_BYTES; k++) begin
        snap_d[k*8 +: 8] = bit_order(bus.TX_IMAGE[k*8 +: 8]);
      end
      snap_valid_d = 1'b1;
      cnt_d        = '0;
      ovf_d        = 1'b0;
      seq_d        = seq_q + 8'd1;
      state_d      = XFER;
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      seq_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      rx_image_q   <= '0;
      rx_update_q  <= 1'b0;
      xfer_err_q   <= 1'b0;
      link_ok_q    <= 1'b0;
      wdt_q        <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      seq_q        <= seq_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      rx_image_q   <= rx_image_d;
      rx_update_q  <= rx_update_d;
      xfer_err_q   <= xfer_err_d;
      link_ok_q    <= link_ok_d;
      wdt_q        <= wdt_d;
    end
  end

  assign bus.SNAP_DATA  = snap_q;
  assign bus.SNAP_VALID = snap_valid_q;
  assign bus.RX_IMAGE   = rx_image_q;
  assign bus.RX_UPDATE  = rx_update_q;
  assign bus.XFER_ERR   = xfer_err_q;
  assign bus.LINK_OK    = link_ok_q;

endmodule
